// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Subtract support is enabled by defining SERIAL_SUB_EN.
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Gate-level full-adder cell used as the one-bit datapath slice of the serial adder.
module serial_adder_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (p & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per cycle, LSB first.
// Optional subtract (op port) when SERIAL_SUB_EN is defined; default build is add-only.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             c_msb_q, c_msb_d;
    logic             sub_q, sub_d;
    logic             start_op;
    logic             fa_b, fa_s, fa_c;

`ifdef SERIAL_SUB_EN
    assign start_op = op;
`else
    assign start_op = 1'b0;
`endif

    // Subtract is A + ~B + 1: invert B bits, carry preloaded with 1 at start.
    assign fa_b = b_sh_q[0] ^ sub_q;

    serial_adder_full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (fa_b),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        c_msb_d = c_msb_q;
        sub_d   = sub_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StShift;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = '0;
                    carry_d = start_op;
                    sub_d   = start_op;
                    sum_d   = '0;
                end
            end
            StShift: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    c_out_d = fa_c;
                    // carry_q here is the carry into the MSB slice
                    c_msb_d = carry_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            c_msb_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            c_msb_q <= c_msb_d;
            sub_q   <= sub_d;
        end
    end

    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = c_out_q ^ c_msb_q;

endmodule
